// File: rtl/neuron_pkg.sv
// Shared types and helpers for the single-neuron trainer and forward datapath.
package neuron_pkg;

  localparam int XW_W_DEF = 2;
  localparam int B_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_UPD  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Clamp a signed value into the range of a signed field of the given width.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/neuron_mac_sat.sv
// Combinational neuron forward pass: y = sat(x*w + b), shared with the forward neuron path.
module neuron_mac_sat
  import neuron_pkg::*;
#(
  parameter int XW_W = XW_W_DEF,
  parameter int B_W  = B_W_DEF
) (
  input  logic [XW_W-1:0] x,
  input  logic [XW_W-1:0] w,
  input  logic [B_W-1:0]  b,
  output logic [B_W-1:0]  y
);

  always_comb begin
    y = B_W'(sat_signed(32'($signed(x)) * 32'($signed(w)) + 32'($signed(b)), B_W));
  end

endmodule

// File: rtl/neuron_trainer.sv
// Perceptron trainer: owns w/b, runs forward pass on each sample, forms the error and updates w/b.
//   state | meaning
//   IDLE  | ready for a sample or a direct w/b load
//   FWD   | forward pass with current w/b, capture y and err
//   UPD   | apply learning update and streak tracking, raise m_valid
//   OUT   | hold result until consumer handshake
module neuron_trainer
  import neuron_pkg::*;
#(
  parameter int XW_W       = XW_W_DEF,
  parameter int B_W        = B_W_DEF,
  parameter int LR_SHIFT   = 0,
  parameter int CONV_COUNT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_en,
  input  logic [XW_W-1:0] ld_w,
  input  logic [B_W-1:0]  ld_b,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [XW_W-1:0] s_x,
  input  logic [B_W-1:0]  s_target,
  input  logic            s_learn,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [B_W-1:0]  m_y,
  output logic [B_W:0]    m_err,
  output logic [XW_W-1:0] w,
  output logic [B_W-1:0]  b,
  output logic            converged
);

  localparam int SW = $clog2(CONV_COUNT + 1);

  state_t          state_q, state_d;
  logic [XW_W-1:0] x_q, x_d;
  logic [XW_W-1:0] w_q, w_d;
  logic [B_W-1:0]  target_q, target_d;
  logic [B_W-1:0]  b_q, b_d;
  logic [B_W-1:0]  m_y_q, m_y_d;
  logic [B_W:0]    m_err_q, m_err_d;
  logic            learn_q, learn_d;
  logic            m_valid_q, m_valid_d;
  logic            conv_q, conv_d;
  logic [SW-1:0]   streak_q, streak_d;

  logic [B_W-1:0]  y_fwd;
  logic [B_W:0]    err_fwd;
  logic [XW_W-1:0] w_upd;
  logic [B_W-1:0]  b_upd;

  neuron_mac_sat #(.XW_W(XW_W), .B_W(B_W)) u_mac (
    .x (x_q),
    .w (w_q),
    .b (b_q),
    .y (y_fwd)
  );

  // Error is exact in B_W+1 bits; updates use wide intermediates before clamping.
  always_comb begin
    err_fwd = (B_W+1)'(32'($signed(target_q)) - 32'($signed(y_fwd)));
    w_upd   = XW_W'(sat_signed(32'($signed(w_q)) +
                ((32'($signed(m_err_q)) * 32'($signed(x_q))) >>> LR_SHIFT), XW_W));
    b_upd   = B_W'(sat_signed(32'($signed(b_q)) +
                (32'($signed(m_err_q)) >>> LR_SHIFT), B_W));
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    target_d  = target_q;
    learn_d   = learn_q;
    w_d       = w_q;
    b_d       = b_q;
    m_y_d     = m_y_q;
    m_err_d   = m_err_q;
    m_valid_d = m_valid_q;
    streak_d  = streak_q;
    s_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready = !ld_en;
        if (ld_en) begin
          w_d      = ld_w;
          b_d      = ld_b;
          streak_d = '0;
        end else if (s_valid) begin
          x_d      = s_x;
          target_d = s_target;
          learn_d  = s_learn;
          state_d  = ST_FWD;
        end
      end
      ST_FWD: begin
        m_y_d   = y_fwd;
        m_err_d = err_fwd;
        state_d = ST_UPD;
      end
      ST_UPD: begin
        if (learn_q) begin
          w_d = w_upd;
          b_d = b_upd;
          if (m_err_q != '0)                    streak_d = '0;
          else if (streak_q != SW'(CONV_COUNT)) streak_d = streak_q + SW'(1);
        end
        m_valid_d = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    conv_d = (streak_d == SW'(CONV_COUNT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      target_q  <= '0;
      learn_q   <= 1'b0;
      w_q       <= '0;
      b_q       <= '0;
      m_y_q     <= '0;
      m_err_q   <= '0;
      m_valid_q <= 1'b0;
      streak_q  <= '0;
      conv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      target_q  <= target_d;
      learn_q   <= learn_d;
      w_q       <= w_d;
      b_q       <= b_d;
      m_y_q     <= m_y_d;
      m_err_q   <= m_err_d;
      m_valid_q <= m_valid_d;
      streak_q  <= streak_d;
      conv_q    <= conv_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_y       = m_y_q;
  assign m_err     = m_err_q;
  assign w         = w_q;
  assign b         = b_q;
  assign converged = conv_q;

endmodule

// File: tb/tb_neuron_trainer.sv
// Scoreboarded bench for neuron_trainer: directed corner cases plus randomized training traffic.
module tb_neuron_trainer;

  localparam int XW_W       = 2;
  localparam int B_W        = 4;
  localparam int LR_SHIFT   = 0;
  localparam int CONV_COUNT = 2;
  localparam int BMAX = (1 << (B_W - 1)) - 1;
  localparam int BMIN = -(1 << (B_W - 1));
  localparam int WMAX = (1 << (XW_W - 1)) - 1;
  localparam int WMIN = -(1 << (XW_W - 1));

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            ld_en = 1'b0;
  logic [XW_W-1:0] ld_w = '0;
  logic [B_W-1:0]  ld_b = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [XW_W-1:0] s_x = '0;
  logic [B_W-1:0]  s_target = '0;
  logic            s_learn = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [B_W-1:0]  m_y;
  logic [B_W:0]    m_err;
  logic [XW_W-1:0] w;
  logic [B_W-1:0]  b;
  logic            converged;

  neuron_trainer #(.XW_W(XW_W), .B_W(B_W), .LR_SHIFT(LR_SHIFT), .CONV_COUNT(CONV_COUNT)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_w(ld_w), .ld_b(ld_b),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_target(s_target), .s_learn(s_learn),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_err(m_err),
    .w(w), .b(b), .converged(converged)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int err;
    int w;
    int b;
    int conv;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   mw = 0, mb = 0, mstreak = 0;
  bit   rand_ready = 1'b0;

  function automatic int clamp(int v, int lo, int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Reference model: plain integer perceptron arithmetic.
  task automatic model_sample(int x, int t, bit learn);
    exp_t e;
    e.y   = clamp(x * mw + mb, BMIN, BMAX);
    e.err = t - e.y;
    if (learn) begin
      mw = clamp(mw + ((e.err * x) >>> LR_SHIFT), WMIN, WMAX);
      mb = clamp(mb + (e.err >>> LR_SHIFT), BMIN, BMAX);
      mstreak = (e.err == 0) ? ((mstreak < CONV_COUNT) ? mstreak + 1 : CONV_COUNT) : 0;
    end
    e.w    = mw;
    e.b    = mb;
    e.conv = (mstreak == CONV_COUNT) ? 1 : 0;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && m_valid && m_ready) begin
      if (q.size() == 0) begin
        timeout("unexpected_result");
      end else begin
        e = q.pop_front();
        check("m_y", int'($signed(m_y)), e.y);
        check("m_err", int'($signed(m_err)), e.err);
        check("w_after_upd", int'($signed(w)), e.w);
        check("b_after_upd", int'($signed(b)), e.b);
        check("converged", int'(converged), e.conv);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || m_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) timeout("wait_idle");
  endtask

  task automatic do_load(int lw, int lb);
    wait_idle();
    ld_w  = XW_W'(lw);
    ld_b  = B_W'(lb);
    ld_en = 1'b1;
    @(negedge clk);
    check("ld_s_ready", int'(s_ready), 0);
    @(posedge clk); #1;
    ld_en = 1'b0;
    mw = lw; mb = lb; mstreak = 0;
    check("ld_w", int'($signed(w)), lw);
    check("ld_b", int'($signed(b)), lb);
    check("ld_conv", int'(converged), 0);
  endtask

  task automatic send(int x, int t, bit learn);
    int n = 0;
    model_sample(x, t, learn);
    s_x      = XW_W'(x);
    s_target = B_W'(t);
    s_learn  = learn;
    s_valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 300);
    if (!s_ready) begin
      timeout("send_accept");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_w", int'(w), 0);
    check("rst_b", int'(b), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_conv", int'(converged), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_s_ready", int'(s_ready), 1);

    // Basic learn with weight clamp, plus result latency
    do_load(1, 0);
    send(1, 3, 1'b1);
    @(negedge clk);
    check("lat_fwd", int'(m_valid), 0);
    @(negedge clk);
    check("lat_upd", int'(m_valid), 0);
    @(negedge clk);
    check("lat_out", int'(m_valid), 1);
    @(posedge clk); #1;

    // Forward saturation with learn off
    do_load(-2, 7);
    send(-2, 7, 1'b0);

    // Convergence streak and clear
    do_load(1, 2);
    send(-1, 1, 1'b1);
    send(-1, 1, 1'b1);
    send(-1, 0, 1'b1);

    // Backpressure: result must hold, extra sample pulses ignored
    wait_idle();
    m_ready = 1'b0;
    send(1, 2, 1'b0);
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_valid) timeout("bp_valid");
    for (int i = 0; i < 5; i++) begin
      s_valid  = 1'b1;
      s_x      = XW_W'($urandom_range(0, 3));
      s_target = B_W'($urandom_range(0, 15));
      @(negedge clk);
      check("bp_m_valid", int'(m_valid), 1);
      check("bp_m_y", int'($signed(m_y)), q[0].y);
      check("bp_m_err", int'($signed(m_err)), q[0].err);
      check("bp_s_ready", int'(s_ready), 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_no_extra", int'(m_valid), 0);
    end
    @(posedge clk); #1;

    // Reset while in UPD drops the sample immediately
    do_load(1, 1);
    send(1, 0, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_w", int'(w), 0);
    check("midrst_b", int'(b), 0);
    check("midrst_m_valid", int'(m_valid), 0);
    q.delete();
    mw = 0; mb = 0; mstreak = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Load and sample together: load wins
    ld_en = 1'b1; ld_w = 2'b11; ld_b = 4'd3;
    s_valid = 1'b1; s_x = 2'b01; s_target = 4'd5; s_learn = 1'b1;
    @(negedge clk);
    check("ldsv_s_ready", int'(s_ready), 0);
    @(posedge clk); #1;
    ld_en = 1'b0; s_valid = 1'b0;
    mw = -1; mb = 3; mstreak = 0;
    check("ldsv_w", int'($signed(w)), -1);
    check("ldsv_b", int'($signed(b)), 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ldsv_no_sample", int'(m_valid), 0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0)
        do_load(int'($urandom_range(0, 3)) - 2, int'($urandom_range(0, 15)) - 8);
      send(int'($urandom_range(0, 3)) - 2, int'($urandom_range(0, 15)) - 8,
           1'($urandom_range(0, 1)));
    end
    @(posedge clk); #1;
    rand_ready = 1'b0;
    m_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
